cr_ahbl_req_arb_mc: RTL and testbench

//  N-master request arbiter in front of the single AHB-Lite master interface in the BIU.

---
 rtl/cr_ahbl_req_arb_mc_pkg.sv | 12 +
 rtl/cr_ahbl_req_arb_mc_if.sv | 30 +++
 rtl/cr_ahbl_owner_fifo.sv | 53 +++++
 rtl/cr_ahbl_req_arb_mc.sv | 103 ++++++++++
 tb/tb_cr_ahbl_req_arb_mc.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_ahbl_req_arb_mc_pkg.sv
// Shared constants for the BIU request arbiter: arbitration modes, fixed
// AHB-Lite attribute widths and the owner-index width helper.
package cr_ahbl_req_arb_mc_pkg;
  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;
  localparam int PROT_W         = 4;
  localparam int SIZE_W         = 2;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cr_ahbl_req_arb_mc_if.sv
// Request/response channel between the arbiter and the single AHB-Lite
// master interface of the BIU.
interface cr_ahbl_req_arb_mc_if
  import cr_ahbl_req_arb_mc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [PROT_W-1:0] cpu_prot;
  logic [SIZE_W-1:0] cpu_size;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_req_grnt;
  logic              cpu_trans_cmplt;
  logic              cpu_data_vld;
  logic              cpu_acc_err;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_prot, cpu_size, cpu_write, cpu_wdata,
    input  cpu_req_grnt, cpu_trans_cmplt, cpu_data_vld, cpu_acc_err, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_prot, cpu_size, cpu_write, cpu_wdata,
    output cpu_req_grnt, cpu_trans_cmplt, cpu_data_vld, cpu_acc_err, cpu_rdata
  );
endinterface

// File: rtl/cr_ahbl_owner_fifo.sv
// Owner-index FIFO: remembers which master owns each granted address phase
// so data-phase responses can be routed back in order.
module cr_ahbl_owner_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             ahbl_gated_clk,
  input  logic             cpurst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [2:0]       cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == 3'(DEPTH));
  assign empty   = (cnt == 3'd0);
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge ahbl_gated_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/cr_ahbl_req_arb_mc.sv
// N-master request arbiter in front of the BIU AHB-Lite master interface:
// fixed-priority or round-robin selection, grant-pending lock, owner tracking.
module cr_ahbl_req_arb_mc
  import cr_ahbl_req_arb_mc_pkg::*;
#(
  parameter int NUM_MST     = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = ARB_MODE_FIXED,
  parameter int OUTST_DEPTH = 2
) (
  input  logic                        ahbl_gated_clk,
  input  logic                        cpurst_b,
  input  logic [NUM_MST-1:0]          mst_req,
  input  logic [NUM_MST*ADDR_W-1:0]   mst_addr,
  input  logic [NUM_MST*PROT_W-1:0]   mst_prot,
  input  logic [NUM_MST*SIZE_W-1:0]   mst_size,
  input  logic [NUM_MST-1:0]          mst_write,
  input  logic [NUM_MST*DATA_W-1:0]   mst_wdata,
  output logic [NUM_MST-1:0]          mst_grnt,
  output logic [NUM_MST-1:0]          mst_trans_cmplt,
  output logic [NUM_MST-1:0]          mst_data_vld,
  output logic [NUM_MST-1:0]          mst_acc_err,
  output logic [DATA_W-1:0]           mst_rdata,
  cr_ahbl_req_arb_mc_if.master        cpu,
  output logic                        arb_lock,
  output logic [2:0]                  arb_outst_cnt
);
  localparam int OWNER_W = owner_w(NUM_MST);

  logic [OWNER_W-1:0] sel, lock_idx, rr_ptr, head;
  logic               fifo_full, fifo_empty, grant;
  logic [NUM_MST-1:0] head_oh;

  always_comb begin : select
    logic [OWNER_W-1:0] start, cand;
    logic               found;
    start = (ARB_MODE == ARB_MODE_RR) ? rr_ptr : '0;
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    if (arb_lock) begin
      sel = lock_idx;
    end else begin
      for (int k = 0; k < NUM_MST; k++) begin
        cand = OWNER_W'((int'(start) + k) % NUM_MST);
        if (!found && mst_req[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Reset gates the request so every output drops asynchronously with cpurst_b.
  assign cpu.cpu_req   = cpurst_b && (|mst_req) && !(fifo_full && !cpu.cpu_trans_cmplt);
  assign grant         = cpu.cpu_req && cpu.cpu_req_grnt;
  assign cpu.cpu_addr  = cpu.cpu_req ? mst_addr[sel*ADDR_W +: ADDR_W] : '0;
  assign cpu.cpu_prot  = cpu.cpu_req ? mst_prot[sel*PROT_W +: PROT_W] : '0;
  assign cpu.cpu_size  = cpu.cpu_req ? mst_size[sel*SIZE_W +: SIZE_W] : '0;
  assign cpu.cpu_write = cpu.cpu_req && mst_write[sel];
  assign mst_grnt      = grant ? (NUM_MST'(1) << sel) : '0;

  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      arb_lock <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      if (grant) rr_ptr <= (sel == OWNER_W'(NUM_MST - 1)) ? '0 : sel + 1'b1;
      if (arb_lock) begin
        // A locked master withdrawing its request is tolerated: re-arbitrate.
        if (grant || !mst_req[lock_idx]) arb_lock <= 1'b0;
      end else if (cpu.cpu_req && !cpu.cpu_req_grnt) begin
        arb_lock <= 1'b1;
        lock_idx <= sel;
      end
    end
  end

  cr_ahbl_owner_fifo #(
    .DEPTH (OUTST_DEPTH),
    .WIDTH (OWNER_W)
  ) u_owner_fifo (
    .ahbl_gated_clk (ahbl_gated_clk),
    .cpurst_b       (cpurst_b),
    .push           (grant),
    .push_data      (sel),
    .pop            (cpu.cpu_trans_cmplt),
    .head           (head),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .cnt            (arb_outst_cnt)
  );

  // Responses with no outstanding owner are dropped.
  assign head_oh         = fifo_empty ? '0 : (NUM_MST'(1) << head);
  assign mst_trans_cmplt = cpu.cpu_trans_cmplt ? head_oh : '0;
  assign mst_data_vld    = cpu.cpu_data_vld    ? head_oh : '0;
  assign mst_acc_err     = cpu.cpu_acc_err     ? head_oh : '0;
  assign mst_rdata       = cpurst_b ? cpu.cpu_rdata : '0;
  assign cpu.cpu_wdata   = fifo_empty ? '0 : mst_wdata[head*DATA_W +: DATA_W];
endmodule

// File: tb/tb_cr_ahbl_req_arb_mc.sv
// Directed bench for cr_ahbl_req_arb_mc: a fixed-priority and a round-robin
// instance share stimulus; owner routing is checked against a queue.
module tb_cr_ahbl_req_arb_mc;
  import cr_ahbl_req_arb_mc_pkg::*;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic [N-1:0]        mst_req = '0;
  logic [N*AW-1:0]     mst_addr;
  logic [N*PROT_W-1:0] mst_prot;
  logic [N*SIZE_W-1:0] mst_size;
  logic [N-1:0]        mst_write;
  logic [N*DW-1:0]     mst_wdata;

  logic [N-1:0]  f_grnt, f_cmplt, f_dvld, f_err, r_grnt, r_cmplt, r_dvld, r_err;
  logic [DW-1:0] f_rdata, r_rdata;
  logic          f_lock, r_lock;
  logic [2:0]    f_cnt, r_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int o;

  cr_ahbl_req_arb_mc_if #(.ADDR_W(AW), .DATA_W(DW)) f ();
  cr_ahbl_req_arb_mc_if #(.ADDR_W(AW), .DATA_W(DW)) r ();

  assign r.cpu_req_grnt    = f.cpu_req_grnt;
  assign r.cpu_trans_cmplt = f.cpu_trans_cmplt;
  assign r.cpu_data_vld    = f.cpu_data_vld;
  assign r.cpu_acc_err     = f.cpu_acc_err;
  assign r.cpu_rdata       = f.cpu_rdata;

  cr_ahbl_req_arb_mc #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW),
                       .ARB_MODE(ARB_MODE_FIXED), .OUTST_DEPTH(2)) u_fix (
    .ahbl_gated_clk (clk), .cpurst_b (rst_b),
    .mst_req (mst_req), .mst_addr (mst_addr), .mst_prot (mst_prot),
    .mst_size (mst_size), .mst_write (mst_write), .mst_wdata (mst_wdata),
    .mst_grnt (f_grnt), .mst_trans_cmplt (f_cmplt), .mst_data_vld (f_dvld),
    .mst_acc_err (f_err), .mst_rdata (f_rdata), .cpu (f),
    .arb_lock (f_lock), .arb_outst_cnt (f_cnt)
  );

  cr_ahbl_req_arb_mc #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW),
                       .ARB_MODE(ARB_MODE_RR), .OUTST_DEPTH(2)) u_rr (
    .ahbl_gated_clk (clk), .cpurst_b (rst_b),
    .mst_req (mst_req), .mst_addr (mst_addr), .mst_prot (mst_prot),
    .mst_size (mst_size), .mst_write (mst_write), .mst_wdata (mst_wdata),
    .mst_grnt (r_grnt), .mst_trans_cmplt (r_cmplt), .mst_data_vld (r_dvld),
    .mst_acc_err (r_err), .mst_rdata (r_rdata), .cpu (r),
    .arb_lock (r_lock), .arb_outst_cnt (r_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h4000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int i);
    return 32'hD0D0_0000 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rsp(input logic grnt, input logic cmplt, input logic dvld, input logic err);
    f.cpu_req_grnt    = grnt;
    f.cpu_trans_cmplt = cmplt;
    f.cpu_data_vld    = dvld;
    f.cpu_acc_err     = err;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      mst_addr[i*AW +: AW]         = addr_of(i);
      mst_wdata[i*DW +: DW]        = wdata_of(i);
      mst_prot[i*PROT_W +: PROT_W] = 4'(i + 5);
      mst_size[i*SIZE_W +: SIZE_W] = 2'(i);
    end
    mst_write   = 3'b101;
    f.cpu_rdata = 32'hCAFE_0001;

    // Reset held with requests and responses active: everything stays quiet.
    mst_req = 3'b111;
    drive_rsp(1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    check("rst_cpu_req", 64'(f.cpu_req), 64'd0);
    check("rst_grnt", 64'(f_grnt), 64'd0);
    check("rst_cmplt", 64'(f_cmplt), 64'd0);
    check("rst_addr", 64'(f.cpu_addr), 64'd0);
    check("rst_lock", 64'(f_lock), 64'd0);
    check("rst_cnt", 64'(f_cnt), 64'd0);
    check("rst_rdata", 64'(f_rdata), 64'd0);
    step();
    mst_req = '0;
    drive_rsp(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst_b = 1'b1;

    // Fixed priority picks master 1 out of 3'b110, then routes its completion.
    step();
    mst_req = 3'b110;
    drive_rsp(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check("t1_grnt", 64'(f_grnt), 64'b010);
    check("t1_addr", 64'(f.cpu_addr), 64'(addr_of(1)));
    check("t1_prot", 64'(f.cpu_prot), 64'd6);
    check("t1_size", 64'(f.cpu_size), 64'd1);
    check("t1_write", 64'(f.cpu_write), 64'd0);
    exp_q.push_back(1);
    step();
    mst_req = '0;
    f.cpu_rdata = 32'h1234_5678;
    drive_rsp(1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    o = exp_q.pop_front();
    check("t1_cnt", 64'(f_cnt), 64'd1);
    check("t1_wdata", 64'(f.cpu_wdata), 64'(wdata_of(o)));
    check("t1_cmplt", 64'(f_cmplt), 64'(3'b001 << o));
    check("t1_dvld", 64'(f_dvld), 64'(3'b001 << o));
    check("t1_rdata", 64'(f_rdata), 64'h1234_5678);
    step();
    drive_rsp(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("t1_cnt_after", 64'(f_cnt), 64'd0);
    check("t1_wdata_empty", 64'(f.cpu_wdata), 64'd0);

    // Ungranted master 2 is locked; a later master 0 request must not steal it.
    step();
    mst_req = 3'b100;
    #2;
    check("t2_addr_first", 64'(f.cpu_addr), 64'(addr_of(2)));
    check("t2_lock_first", 64'(f_lock), 64'd0);
    step();
    #2;
    check("t2_lock_set", 64'(f_lock), 64'd1);
    step();
    step();
    mst_req = 3'b101;
    #2;
    check("t2_lock_hold", 64'(f_lock), 64'd1);
    check("t2_addr_hold", 64'(f.cpu_addr), 64'(addr_of(2)));
    check("t2_no_grnt", 64'(f_grnt), 64'd0);
    step();
    drive_rsp(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check("t2_grnt", 64'(f_grnt), 64'b100);
    check("t2_write", 64'(f.cpu_write), 64'd1);
    exp_q.push_back(2);

    // Second outstanding grant (master 0) fills the FIFO.
    step();
    mst_req = 3'b001;
    #2;
    check("t4_lock_clr", 64'(f_lock), 64'd0);
    check("t4_grnt0", 64'(f_grnt), 64'b001);
    check("t4_cnt1", 64'(f_cnt), 64'd1);
    exp_q.push_back(0);
    step();
    mst_req = 3'b010;
    #2;
    check("t4_cnt2", 64'(f_cnt), 64'd2);
    check("t4_full_req", 64'(f.cpu_req), 64'd0);
    check("t4_full_grnt", 64'(f_grnt), 64'd0);

    // Completion at full frees a slot for a same-cycle push.
    step();
    f.cpu_rdata = 32'hBEEF_0002;
    drive_rsp(1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    o = exp_q.pop_front();
    check("t5_req_pop", 64'(f.cpu_req), 64'd1);
    check("t5_grnt1", 64'(f_grnt), 64'b010);
    check("t5_dvld", 64'(f_dvld), 64'(3'b001 << o));
    check("t5_cmplt", 64'(f_cmplt), 64'(3'b001 << o));
    check("t5_err_none", 64'(f_err), 64'd0);
    check("t5_wdata", 64'(f.cpu_wdata), 64'(wdata_of(o)));
    exp_q.push_back(1);
    step();
    mst_req = '0;
    drive_rsp(1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    o = exp_q.pop_front();
    check("t4_cnt_kept", 64'(f_cnt), 64'd2);
    check("t5_err", 64'(f_err), 64'(3'b001 << o));
    check("t5_cmplt2", 64'(f_cmplt), 64'(3'b001 << o));
    check("t5_dvld_none", 64'(f_dvld), 64'd0);
    step();
    mst_req = 3'b100;
    drive_rsp(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("t5_cnt1", 64'(f_cnt), 64'd1);
    check("t5_wdata_wrap", 64'(f.cpu_wdata), 64'(wdata_of(exp_q[0])));

    // Asynchronous reset with an outstanding transfer and a lock pending.
    step();
    #1;
    check("t6_pre_lock", 64'(f_lock), 64'd1);
    check("t6_pre_cnt", 64'(f_cnt), 64'd1);
    #2;
    rst_b = 1'b0;
    drive_rsp(1'b1, 1'b1, 1'b1, 1'b1);
    exp_q.delete();
    #1;
    check("t6_lock", 64'(f_lock), 64'd0);
    check("t6_cnt", 64'(f_cnt), 64'd0);
    check("t6_req", 64'(f.cpu_req), 64'd0);
    check("t6_grnt", 64'(f_grnt), 64'd0);
    check("t6_cmplt", 64'(f_cmplt), 64'd0);
    check("t6_err", 64'(f_err), 64'd0);
    check("t6_addr", 64'(f.cpu_addr), 64'd0);
    check("t6_wdata", 64'(f.cpu_wdata), 64'd0);
    step();
    step();
    mst_req = '0;
    drive_rsp(1'b0, 1'b1, 1'b1, 1'b0);
    rst_b = 1'b1;
    #2;
    check("t6_drop_cmplt", 64'(f_cmplt), 64'd0);
    check("t6_drop_dvld", 64'(f_dvld), 64'd0);
    step();
    drive_rsp(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("t6_drop_cnt", 64'(f_cnt), 64'd0);
    check("t6_drop_lock", 64'(f_lock), 64'd0);

    // Round-robin rotation with all masters requesting; fixed stays on 0.
    for (int i = 0; i < 4; i++) begin
      logic [2:0] exp_rr;
      exp_rr = 3'b001 << (i % N);
      step();
      mst_req = 3'b111;
      drive_rsp(1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      check($sformatf("t3_rr_grnt%0d", i), 64'(r_grnt), 64'(exp_rr));
      check($sformatf("t3_fix_grnt%0d", i), 64'(f_grnt), 64'b001);
    end
    step();
    mst_req = '0;
    drive_rsp(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
